uart_rx_deframer: RTL and testbench
===================================

// Module: uart_rx_deframer
// PURPOSE
//  UART receive stage directly upstream of the RX FIFO storage. Oversamples the serial line
//  at 16x via an external baud tick, deframes start/data/parity/stop bits and emits one word
//  per good frame. rx_done_tick drives the FIFO write enable; rx_word drives its write data.
// PARAMETERS
//  DBIT        8    data bits per frame, LSB first
//  PARITY_EN   1    1: one parity bit follows the data; 0: no parity bit
//  PARITY_ODD  0    0: even parity; 1: odd parity (ignored when PARITY_EN=0)
//  SB_TICK     16   ticks sampled in stop state (16 = 1 stop bit, 32 = 2 stop bits)
//  Data_bits   9    output word width; must equal DBIT+1
// PORTS
//  clk           in   1          single clock; every flop is rising-edge triggered
//  rst           in   1          synchronous, active-high reset
//  s_tick        in   1          1-cycle pulse at 16x baud rate from the baud generator
//  rx            in   1          asynchronous serial line, idle high
//  rx_done_tick  out  1          1-cycle pulse: rx_word is valid (FIFO w_en)
//  rx_word       out  Data_bits  {parity_err, data[DBIT-1:0]} (FIFO w_data)
//  frame_err     out  1          1-cycle pulse: stop bit sampled low; frame discarded
//  busy          out  1          high in every state except IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; rx synchroniser flops=1; tick cnt s, bit cnt n, shift reg b = 0;
//    rx_done_tick=0, rx_word=0, frame_err=0, busy=0. Reset mid-frame aborts with no output.
//  - rx passes through a 2-FF synchroniser (rx_s); all decisions use rx_s only.
//  - s (4 bit) advances only on cycles with s_tick=1; n counts 0..DBIT-1.
//  - FSM:
//    IDLE:    rx_s==0 -> START, s=0.
//    START:   on tick with s==7 (mid start bit): rx_s==0 -> DATA, s=0, n=0;
//             rx_s==1 -> IDLE (glitch rejected, no output).
//    DATA:    on tick with s==15: b={rx_s, b[DBIT-1:1]}, s=0; when n==DBIT-1 go to
//             PARITY if PARITY_EN, else STOP; otherwise n++.
//    PARITY:  on tick with s==15: perr = (^b ^ rx_s ^ PARITY_ODD), s=0 -> STOP.
//    STOP:    on tick with s==SB_TICK-1 (s widened to cover SB_TICK):
//             rx_s==1 -> rx_done_tick=1, rx_word={perr,b} -> IDLE;
//             rx_s==0 -> frame_err=1, no rx_done_tick -> BRK_WAIT.
//    BRK_WAIT: stay until rx_s==1 -> IDLE (break line yields exactly one frame_err).
//  - Outputs are registered: pulses assert the cycle after the deciding tick; they are never
//    high together.
//  - rx_word holds its value until the next rx_done_tick and is not updated on frame_err.
//  - perr is forced to 0 when PARITY_EN=0. A parity error does not discard the frame.
//  - Back-to-back frames: IDLE accepts a new start bit on the cycle after the STOP exit.
//    Minimum frame spacing is therefore 0 idle bits.
//  - No backpressure: the FIFO full flag is not an input. Overflow handling is the FIFO's job.
//  - s_tick coinciding with rst: reset wins.
// STRUCTURE
//  - uart_pkg: rx_state_t enum {IDLE, START, DATA, PARITY, STOP, BRK_WAIT}; OVERSAMPLE=16;
//    MID_TICK=7.
//  - One sub-module: sync_2ff (parametrised reset value, used here with 1); all else inline.
//  - Static assertion: Data_bits == DBIT+1.
// TESTING
//  1 Frame 0x55 with parity 0 (even), 1 stop, 16 ticks per bit -> one rx_done_tick;
//    rx_word=9'h055; frame_err=0.
//  2 Frame 0xA3 with wrong parity bit 1 -> rx_done_tick; rx_word=9'h1A3 (parity_err set).
//  3 rx low for 4 ticks then high (glitch) -> no output; busy falls; back in IDLE.
//  4 Frame 0x3C with stop bit 0, then line held low 40 bit times -> exactly one frame_err
//    pulse; no rx_done_tick; busy=1 until rx returns high.
//  5 Three back-to-back frames 0x01, 0x80, 0xFF (no idle gap) -> three rx_done_tick pulses,
//    in order, with rx_word=9'h001, 9'h080, 9'h0FF.
//  6 Assert rst during DATA bit 4 of 0x77, then send 0x12 -> no output for 0x77;
//    rx_word=9'h012; all outputs 0 in the cycle after rst.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and oversampling constants
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} rx_state_t;
    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK = 7;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    // shift the async input through two flops, both loaded with RST_VAL on reset
    always_ff @(posedge clk) begin
        if (rst) {meta, q} <= {2{RST_VAL}};
        else     {meta, q} <= {d, meta};
    end
endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 16x oversampled UART receiver emitting {parity_err, data} per good frame
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int SB_TICK    = 16,
    parameter int Data_bits  = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_tick,
    input  logic                 rx,
    output logic                 rx_done_tick,
    output logic [Data_bits-1:0] rx_word,
    output logic                 frame_err,
    output logic                 busy
);
    if (Data_bits != DBIT + 1) begin : g_bad_width
        $error("uart_rx_deframer: Data_bits must equal DBIT+1");
    end

    // s must also reach SB_TICK-1 when two stop bits are configured
    localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    rx_state_t           state, state_n;
    logic [SW-1:0]       s, s_n;
    logic [NW-1:0]       n, n_n;
    logic [DBIT-1:0]     b, b_n;
    logic                perr, perr_n, done_n, ferr_n, rx_s;
    logic [Data_bits-1:0] word_n;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));

    assign busy = (state != IDLE);

    // state, counters, shift register and registered output pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            perr         <= 1'b0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            rx_word      <= '0;
        end else begin
            state        <= state_n;
            s            <= s_n;
            n            <= n_n;
            b            <= b_n;
            perr         <= perr_n;
            rx_done_tick <= done_n;
            frame_err    <= ferr_n;
            rx_word      <= word_n;
        end
    end

    // next-state decode; sampling decisions happen only on s_tick cycles
    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        b_n     = b;
        perr_n  = perr;
        done_n  = 1'b0;
        ferr_n  = 1'b0;
        word_n  = rx_word;
        case (state)
            IDLE: if (!rx_s) begin
                state_n = START;
                s_n     = '0;
            end
            START: if (s_tick) begin
                if (s == SW'(MID_TICK)) begin
                    state_n = rx_s ? IDLE : DATA;
                    s_n     = '0;
                    n_n     = '0;
                end else s_n = s + SW'(1);
            end
            DATA: if (s_tick) begin
                if (s == SW'(OVERSAMPLE - 1)) begin
                    b_n = {rx_s, b[DBIT-1:1]};
                    s_n = '0;
                    if (n == NW'(DBIT - 1)) state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    else n_n = n + NW'(1);
                end else s_n = s + SW'(1);
            end
            PARITY: if (s_tick) begin
                if (s == SW'(OVERSAMPLE - 1)) begin
                    perr_n  = ^b ^ rx_s ^ (PARITY_ODD != 0);
                    s_n     = '0;
                    state_n = STOP;
                end else s_n = s + SW'(1);
            end
            STOP: if (s_tick) begin
                if (s == SW'(SB_TICK - 1)) begin
                    s_n     = '0;
                    state_n = rx_s ? IDLE : BRK_WAIT;
                    done_n  = rx_s;
                    ferr_n  = !rx_s;
                    word_n  = rx_s ? {(PARITY_EN != 0) && perr, b} : rx_word;
                end else s_n = s + SW'(1);
            end
            BRK_WAIT: if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: scoreboard bench for the UART receive deframer
module tb_uart_rx_deframer;
    logic       clk = 1'b0, rst = 1'b1, s_tick = 1'b0, rx = 1'b1;
    logic       rx_done_tick, frame_err, busy;
    logic [8:0] rx_word;
    logic [1:0] tcnt = '0;
    int         total = 0, bad = 0, n_done = 0, n_ferr = 0;
    logic [8:0] exp_q[$];

    uart_rx_deframer dut (
        .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx),
        .rx_done_tick(rx_done_tick), .rx_word(rx_word),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // one s_tick every 4 clocks: a bit time is 64 clocks
    always @(posedge clk) begin
        tcnt   <= tcnt + 2'd1;
        s_tick <= (tcnt == 2'd3);
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // pop the expected word on each done pulse; count frame errors
    always @(negedge clk) begin
        if (rx_done_tick) begin
            n_done++;
            chk("done_ferr_excl", {31'd0, frame_err}, 32'd0);
            if (exp_q.size() == 0) chk("extra_word", exp_q.size(), 32'd1);
            else chk("word", {23'd0, rx_word}, {23'd0, exp_q.pop_front()});
        end
        if (frame_err) n_ferr++;
    end

    task automatic send_bit(logic v);
        rx = v;
        repeat (64) @(negedge clk);
    endtask

    task automatic send_frame(logic [7:0] d, logic p, logic sb);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(sb);
    endtask

    task automatic send_good(logic [7:0] d, logic p);
        exp_q.push_back({^d ^ p, d});
        send_frame(d, p, 1'b1);
    endtask

    initial begin
        logic [7:0] d77;
        d77 = 8'h77;
        repeat (5) @(negedge clk);
        chk("rst_done", {31'd0, rx_done_tick}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_word", {23'd0, rx_word}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        send_good(8'h55, 1'b0);
        send_bit(1'b1);
        send_good(8'hA3, 1'b0 ^ 1'b1);
        send_bit(1'b1);
        chk("n_done_t2", n_done, 32'd2);
        chk("word_t2", {23'd0, rx_word}, 32'h1A3);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        chk("busy_glitch", {31'd0, busy}, 32'd1);
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        chk("busy_after_glitch", {31'd0, busy}, 32'd0);
        chk("n_done_glitch", n_done, 32'd2);
        chk("n_ferr_glitch", n_ferr, 32'd0);
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (40 * 64) @(negedge clk);
        chk("busy_break", {31'd0, busy}, 32'd1);
        chk("n_ferr_break", n_ferr, 32'd1);
        chk("word_held", {23'd0, rx_word}, 32'h1A3);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        chk("busy_break_end", {31'd0, busy}, 32'd0);
        chk("n_ferr_after", n_ferr, 32'd1);
        chk("n_done_break", n_done, 32'd2);
        send_good(8'h01, 1'b1);
        send_good(8'h80, 1'b1);
        send_good(8'hFF, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("n_done_b2b", n_done, 32'd5);
        chk("word_b2b", {23'd0, rx_word}, 32'h0FF);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d77[i]);
        rx = d77[4];
        repeat (32) @(negedge clk);
        rst = 1'b1;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_done", {31'd0, rx_done_tick}, 32'd0);
        chk("post_rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_word", {23'd0, rx_word}, 32'd0);
        repeat (100) @(negedge clk);
        chk("n_done_rst", n_done, 32'd5);
        send_good(8'h12, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("n_done_final", n_done, 32'd6);
        chk("queue_left", exp_q.size(), 32'd0);
        chk("n_ferr_final", n_ferr, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
